// File: rtl/pattern_bist_driver.sv
// Drives DUT inputs from a Galois LFSR and folds its outputs into a 16-bit MISR signature.
// States: IDLE wait for start | RUN apply patterns | DRAIN flush DUT latency | DONE hold signature
module pattern_bist_driver #(
  parameter int          PI_W      = 11,
  parameter int          PO_W      = 9,
  parameter int          PATTERNS  = 256,
  parameter int          LATENCY   = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter logic [15:0] MISR_SEED = 16'h0000
) (
  input  logic            blif_clk_net,
  input  logic            blif_reset_net,
  input  logic            start,
  input  logic [PO_W-1:0] po_vec,
  input  logic [15:0]     golden,
  output logic [PI_W-1:0] pi_vec,
  output logic            busy,
  output logic            done,
  output logic [15:0]     signature,
  output logic            pass
);

  localparam logic [15:0] POLY = 16'h6801;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [15:0]        sig_q, sig_d;
  logic [3:0]         drain_q, drain_d;
  logic [LATENCY-1:0] vpipe_q;
  logic [PI_W-1:0]    pi_raw;

  // Pattern bits beyond the 16-bit LFSR are tied low.
  if (PI_W <= 16) begin : g_pi_narrow
    assign pi_raw = lfsr_q[PI_W-1:0];
  end else begin : g_pi_wide
    assign pi_raw = {{(PI_W-16){1'b0}}, lfsr_q};
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
    drain_d = drain_q;
    if (vpipe_q[LATENCY-1]) begin
      sig_d = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? POLY : 16'h0000) ^ 16'(po_vec);
    end
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          lfsr_d  = LFSR_SEED;
          cnt_d   = '0;
          sig_d   = MISR_SEED;
        end
      end
      S_RUN: begin
        lfsr_d = {lfsr_q[14:0], 1'b0} ^ (lfsr_q[15] ? POLY : 16'h0000);
        cnt_d  = cnt_q + 16'd1;
        if (cnt_q == 16'(PATTERNS - 1)) begin
          state_d = S_DRAIN;
          drain_d = 4'(LATENCY - 1);
        end
      end
      S_DRAIN: begin
        if (drain_q == 4'd0) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge blif_clk_net) begin
    if (blif_reset_net) begin
      state_q <= S_IDLE;
      lfsr_q  <= LFSR_SEED;
      cnt_q   <= '0;
      sig_q   <= MISR_SEED;
      drain_q <= '0;
      vpipe_q <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      cnt_q      <= cnt_d;
      sig_q      <= sig_d;
      drain_q    <= drain_d;
      // Delays "pattern applied" to the cycle its response appears on po_vec.
      vpipe_q[0] <= (state_q == S_RUN);
      for (int i = 1; i < LATENCY; i++) begin
        vpipe_q[i] <= vpipe_q[i-1];
      end
    end
  end

  assign pi_vec    = (state_q == S_RUN) ? pi_raw : '0;
  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign signature = sig_q;
  assign pass      = done && (sig_q == golden);

endmodule

// File: tb/tb_pattern_bist_driver.sv
// Bench for pattern_bist_driver: three configurations, expected signatures queued per run.
module tb_pattern_bist_driver;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  start_v;
  logic [15:0] golden_v [3];
  logic [10:0] pi_v [3];
  logic [2:0]  busy_v, done_v, pass_v;
  logic [15:0] sig_v [3];
  logic [8:0]  po0, po1, po2;
  logic [8:0]  s1, s2;

  int n_pass = 0;
  int n_total = 0;
  logic [16:0] q0[$], q1[$], q2[$];
  logic [15:0] model;

  pattern_bist_driver u_dflt (
    .blif_clk_net(clk), .blif_reset_net(rst), .start(start_v[0]), .po_vec(po0),
    .golden(golden_v[0]), .pi_vec(pi_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .signature(sig_v[0]), .pass(pass_v[0]));

  pattern_bist_driver #(.PATTERNS(2), .LATENCY(2), .PO_W(9)) u_t3 (
    .blif_clk_net(clk), .blif_reset_net(rst), .start(start_v[1]), .po_vec(po1),
    .golden(golden_v[1]), .pi_vec(pi_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .signature(sig_v[1]), .pass(pass_v[1]));

  pattern_bist_driver #(.PATTERNS(4), .LATENCY(2)) u_t4 (
    .blif_clk_net(clk), .blif_reset_net(rst), .start(start_v[2]), .po_vec(po2),
    .golden(golden_v[2]), .pi_vec(pi_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .signature(sig_v[2]), .pass(pass_v[2]));

  // Stand-in DUT for the default instance: two flop stages of a simple XOR fold.
  always @(posedge clk) begin
    s1 <= pi_v[0][8:0] ^ pi_v[0][10:2];
    s2 <= s1;
  end
  assign po0 = s2;
  assign po1 = 9'h001;

  function automatic logic [15:0] galois(input logic [15:0] v);
    return {v[14:0], 1'b0} ^ (v[15] ? 16'h6801 : 16'h0000);
  endfunction

  function automatic logic [15:0] model_sig();
    logic [15:0] lf, sg;
    logic [10:0] p;
    lf = 16'hACE1;
    sg = 16'h0000;
    for (int j = 0; j < 256; j++) begin
      p  = lf[10:0];
      sg = galois(sg) ^ {7'b0, p[8:0] ^ p[10:2]};
      lf = galois(lf);
    end
    return sg;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push(input int d, input logic [15:0] s, input logic p);
    case (d)
      0: q0.push_back({s, p});
      1: q1.push_back({s, p});
      default: q2.push_back({s, p});
    endcase
  endtask

  task automatic pop_check(input int d);
    logic [16:0] e;
    bit          empty;
    empty = 1'b0;
    e     = '0;
    case (d)
      0: if (q0.size() == 0) empty = 1'b1; else e = q0.pop_front();
      1: if (q1.size() == 0) empty = 1'b1; else e = q1.pop_front();
      default: if (q2.size() == 0) empty = 1'b1; else e = q2.pop_front();
    endcase
    if (empty) begin
      n_total++;
      $display("FAIL unexpected_done inst %0d: signature %0h with no expected entry", d, sig_v[d]);
    end else begin
      chk($sformatf("signature[%0d]", d), 32'(sig_v[d]), 32'(e[16:1]));
      chk($sformatf("pass[%0d]", d), 32'(pass_v[d]), 32'(e[0]));
    end
  endtask

  initial begin
    logic [2:0] prev;
    prev = '0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (done_v[d] && !prev[d]) pop_check(d);
      end
      prev = done_v;
    end
  end

  task automatic run(input int d, input bit stream, input int again_at, input int flip_at,
                     input int rst_at, input int exp_busy);
    int n;
    bit aborted;
    @(negedge clk);
    start_v[d] = 1'b1;
    @(negedge clk);
    start_v[d] = 1'b0;
    chk("done_drop", 32'(done_v[d]), 32'd0);
    chk("busy_rise", 32'(busy_v[d]), 32'd1);
    n = 1;
    aborted = 1'b0;
    while (busy_v[d] && n <= 400) begin
      if (stream && n == 1) chk("pi_first", 32'(pi_v[d]), 32'h4E1);
      if (stream && n == 2) chk("pi_second", 32'(pi_v[d]), 32'h1C3);
      start_v[d] = (n == again_at);
      po2 = (n == flip_at) ? 9'h004 : 9'h000;
      if (n == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        aborted = 1'b1;
        break;
      end
      @(negedge clk);
      n++;
    end
    start_v[d] = 1'b0;
    po2 = 9'h000;
    if (aborted) begin
      chk("rst_pi", 32'(pi_v[d]), 32'd0);
      chk("rst_busy", 32'(busy_v[d]), 32'd0);
      chk("rst_done", 32'(done_v[d]), 32'd0);
      chk("rst_sig", 32'(sig_v[d]), 32'd0);
    end else begin
      chk("busy_len", 32'(n - 1), 32'(exp_busy));
      chk("done_rise", 32'(done_v[d]), 32'd1);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    start_v = '0;
    po2 = 9'h000;
    for (int i = 0; i < 3; i++) golden_v[i] = 16'h0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_pi", 32'(pi_v[0]), 32'd0);
    chk("reset_busy", 32'(busy_v[0]), 32'd0);
    chk("reset_done", 32'(done_v[0]), 32'd0);
    chk("reset_pass", 32'(pass_v[0]), 32'd0);
    chk("reset_sig", 32'(sig_v[0]), 32'd0);

    model = model_sig();

    golden_v[0] = model;
    push(0, model, 1'b1);
    run(0, 1'b1, 0, 0, 0, 258);

    push(0, model, 1'b1);
    run(0, 1'b0, 10, 0, 0, 258);

    run(0, 1'b0, 0, 0, 50, 0);
    push(0, model, 1'b1);
    run(0, 1'b1, 0, 0, 0, 258);
    golden_v[0] = model ^ 16'h0001;
    #1;
    chk("pass_wrong_golden", 32'(pass_v[0]), 32'd0);

    golden_v[1] = 16'h0003;
    push(1, 16'h0003, 1'b1);
    run(1, 1'b1, 0, 0, 0, 4);
    golden_v[1] = 16'h0002;
    push(1, 16'h0003, 1'b0);
    run(1, 1'b0, 0, 0, 0, 4);

    golden_v[2] = 16'h0000;
    push(2, 16'h0008, 1'b0);
    run(2, 1'b0, 0, 5, 0, 6);
    push(2, 16'h0000, 1'b1);
    run(2, 1'b0, 0, 0, 0, 6);

    repeat (3) @(negedge clk);
    chk("queues_drained", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
